// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, synchronous flush and
// saturating bubble/flush counters for performance debug.
//
// state | meaning
// EMPTY | nothing held, out_valid=0
// ONE   | main entry valid, skid empty
// FULL  | main and skid valid, upstream stalled
module pipe_stage_skid_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t              state_q;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic                out_valid_q, in_ready_q;
  logic [CNT_W-1:0]    bubble_cnt_q, flush_cnt_q;
  logic [CNT_W-1:0]    bubble_cnt_d, flush_cnt_d;
  logic                accept, drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      // data fields are left alone; only control is killed
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
            state_q     <= FULL;
            in_ready_q  <= 1'b0;
          end else if (accept && drain) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
          end else if (drain) begin
            main_ctrl_q <= '0;
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            skid_ctrl_q <= '0;
            state_q     <= ONE;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          main_ctrl_q <= '0;
          skid_ctrl_q <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // clear wins over increment; both counters ignore flush for clearing
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (cnt_clr) begin
      bubble_cnt_d = '0;
      flush_cnt_d  = '0;
    end else begin
      if (!out_valid_q && (bubble_cnt_q != '1))
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      if (flush && (state_q != EMPTY) && (flush_cnt_q != '1))
        flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: a queue scoreboard holds accepted
// entries and is popped and compared on every downstream drain.
module tb_pipe_stage_skid_reg;
  localparam int CW = 8;
  localparam int DW = 24;
  localparam int NW = 4;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic          cnt_clr;
  logic [NW-1:0] bubble_cnt;
  logic [NW-1:0] flush_cnt;

  pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .cnt_clr    (cnt_clr),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          sb[$];
  int            n_chk;
  int            n_fail;
  logic          m_rdy;
  logic [NW-1:0] m_bub;
  logic [NW-1:0] m_fl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
    return {c, c ^ 8'hC3, c + 8'd1};
  endfunction

  // Drive one cycle of stimulus, check the registered outputs, update the
  // model for the coming edge, then advance to 1 time unit past that edge.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic ordy,
                      input logic fl = 1'b0, input logic clr = 1'b0);
    logic was_empty;
    logic acc;
    logic drn;
    ent_t e;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = mk_data(c);
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    was_empty = (sb.size() == 0);
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, !was_empty});
    if (was_empty) chk("out_ctrl_bubble", {56'd0, out_ctrl}, 64'd0);
    else           chk("out_ctrl_head", {56'd0, out_ctrl}, {56'd0, sb[0].c});
    chk("bubble_cnt", {60'd0, bubble_cnt}, {60'd0, m_bub});
    chk("flush_cnt", {60'd0, flush_cnt}, {60'd0, m_fl});
    acc = v & m_rdy & !fl;
    drn = !was_empty & ordy;
    if (drn) begin
      e = sb.pop_front();
      chk("drain_ctrl", {56'd0, out_ctrl}, {56'd0, e.c});
      chk("drain_data", {40'd0, out_data}, {40'd0, e.d});
    end
    if (clr) begin
      m_bub = '0;
      m_fl  = '0;
    end else begin
      if (was_empty && m_bub != '1) m_bub = m_bub + 1'b1;
      if (fl && !was_empty && m_fl != '1) m_fl = m_fl + 1'b1;
    end
    if (fl) sb.delete();
    else if (acc) begin
      e.c = c;
      e.d = mk_data(c);
      sb.push_back(e);
    end
    m_rdy = (sb.size() < 2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    m_rdy     = 1'b1;
    m_bub     = '0;
    m_fl      = '0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    chk("rst_out_data", {40'd0, out_data}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_bubble", {60'd0, bubble_cnt}, 64'd0);
    chk("rst_flush", {60'd0, flush_cnt}, 64'd0);
    #1 reset = 1'b1;

    // streaming at full throughput
    step(1'b1, 8'h11, 1'b1);
    step(1'b1, 8'h22, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    chk("stream_bubble", {60'd0, bubble_cnt}, 64'd1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // backpressure: fill, offer a third entry that must be refused, drain
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    step(1'b1, 8'hA7, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // flush while FULL, with a live offer that must be discarded
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b1, 8'h5C, 1'b0, 1'b1);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_cnt_one", {60'd0, flush_cnt}, 64'd1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("flush_idle_cnt", {60'd0, flush_cnt}, 64'd1);

    // asynchronous reset while stalled FULL
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_bubble", {60'd0, bubble_cnt}, 64'd0);
    sb.delete();
    m_rdy = 1'b1;
    m_bub = '0;
    m_fl  = '0;
    #1 reset = 1'b1;

    // saturation and clear
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
    chk("bubble_sat", {60'd0, bubble_cnt}, 64'd15);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("bubble_clr", {60'd0, bubble_cnt}, 64'd0);

    // a short mixed stream after reset
    step(1'b1, 8'hD1, 1'b1);
    step(1'b1, 8'hD2, 1'b0);
    step(1'b1, 8'hD3, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
